cordic_prerot_seq: RTL and testbench

- Upstream feeder for the 16-iteration combinational CORDIC rotator used for FFT twiddle multiplication.
- Accepts a streaming complex sample per handshake and counts samples within an N-point frame.
- Derives each sample's twiddle exponent and folds the twiddle angle to ±45° by a quadrant pre-rotation of the data, so the CORDIC only ever sees |z| ≤ 23040 (45° at 512 units/degree).
- Emits pre-rotated data plus the residual angle z, registered, with valid/ready flow control.

---
 rtl/cordic_pkg.sv | 34 +++
 rtl/cordic_quad_rot.sv | 69 ++++++
 rtl/cordic_prerot_seq.sv | 142 ++++++++++++++
 tb/tb_cordic_prerot_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Definitions shared by the CORDIC rotator and its pre-rotation feeder: widths,
// angle scale (512 units/degree), step function and the arctangent table.
package cordic_pkg;

   localparam int DATA_W       = 16;
   localparam int ANGLE_W      = 16;
   localparam int DEG_UNITS    = 512;
   localparam int FULL_TURN    = 360 * DEG_UNITS;
   localparam int ANGLE_45     = 45 * DEG_UNITS;
   localparam int CORDIC_ITERS = 16;

   typedef logic signed [ANGLE_W-1:0] angle_t;

   // Multiplier applied to the data is (-j)^q
   typedef enum logic [1:0] {
      QUAD_0   = 2'd0,
      QUAD_90  = 2'd1,
      QUAD_180 = 2'd2,
      QUAD_270 = 2'd3
   } quad_e;

   // atan(2^-i) in angle units, rounded to nearest
   localparam angle_t THETA_TAB [CORDIC_ITERS] = '{
      16'sd23040, 16'sd13601, 16'sd7187, 16'sd3648,
      16'sd1831,  16'sd916,   16'sd458,  16'sd229,
      16'sd115,   16'sd57,    16'sd29,   16'sd14,
      16'sd7,     16'sd4,     16'sd2,    16'sd1
   };

   function automatic int angle_step(input int log2n);
      return FULL_TURN >> log2n;
   endfunction

endpackage

// File: rtl/cordic_quad_rot.sv
// Combinational quadrant rotation by (-j)^q with saturating negation.
// With CORDIC_PRESCALE_EN defined the result is also scaled by ~1/K (0.607422).
module cordic_quad_rot
   import cordic_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  quad_e               q,
   input  logic signed [W-1:0] re,
   input  logic signed [W-1:0] im,
   output logic signed [W-1:0] rot_re,
   output logic signed [W-1:0] rot_im
);

   localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

   function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
      return (x == MIN_V) ? MAX_V : -x;
   endfunction

   logic signed [W-1:0] pre_re;
   logic signed [W-1:0] pre_im;

   always_comb begin
      pre_re = re;
      pre_im = im;
      case (q)
         QUAD_0: begin
            pre_re = re;
            pre_im = im;
         end
         QUAD_90: begin
            pre_re = im;
            pre_im = sat_neg(re);
         end
         QUAD_180: begin
            pre_re = sat_neg(re);
            pre_im = sat_neg(im);
         end
         QUAD_270: begin
            pre_re = sat_neg(im);
            pre_im = re;
         end
         default: begin
            pre_re = re;
            pre_im = im;
         end
      endcase
   end

`ifdef CORDIC_PRESCALE_EN
   // Two guard bits keep the shift-add sum exact; the result magnitude is < 0.61*|x|
   function automatic logic signed [W-1:0] prescale(input logic signed [W-1:0] x);
      logic signed [W+1:0] xe;
      logic signed [W+1:0] y;
      xe = (W+2)'(x);
      y  = (xe >>> 1) + (xe >>> 3) - (xe >>> 6) - (xe >>> 9);
      return y[W-1:0];
   endfunction

   assign rot_re = prescale(pre_re);
   assign rot_im = prescale(pre_im);
`else
   assign rot_re = pre_re;
   assign rot_im = pre_im;
`endif

endmodule

// File: rtl/cordic_prerot_seq.sv
// CORDIC feeder: counts samples per frame, derives the twiddle exponent, folds the
// angle to +/-45 deg and pre-rotates the data (S1 fold, S2 rotate). Macro: CORDIC_PRESCALE_EN.
module cordic_prerot_seq #(
   parameter int LOG2N   = 6,
   parameter int DATA_W  = cordic_pkg::DATA_W,
   parameter int ANGLE_W = cordic_pkg::ANGLE_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic [3:0]                cfg_stride_log2,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  in_real,
   input  logic signed [DATA_W-1:0]  in_img,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  out_real,
   output logic signed [DATA_W-1:0]  out_img,
   output logic signed [ANGLE_W-1:0] out_z,
   output logic                      out_last
);

   import cordic_pkg::quad_e;
   import cordic_pkg::angle_step;

   localparam int N    = 1 << LOG2N;
   localparam int N4   = N / 4;
   localparam int N8   = N / 8;
   localparam int STEP = angle_step(LOG2N);

   logic                      s1_adv;
   logic                      s2_adv;
   logic                      accept;

   logic [LOG2N-1:0]          n_q;
   logic [3:0]                stride_q;

   logic                      s1_valid;
   logic signed [DATA_W-1:0]  s1_re;
   logic signed [DATA_W-1:0]  s1_im;
   quad_e                     s1_q;
   logic signed [ANGLE_W-1:0] s1_z;
   logic                      s1_last;
   logic                      s2_valid;

   logic [LOG2N-1:0]          e;
   logic [1:0]                q_raw;
   logic [LOG2N-3:0]          r;
   int                        r_i;
   int                        z_full;
   quad_e                     q_fold;
   logic signed [ANGLE_W-1:0] z_next;

   logic signed [DATA_W-1:0]  rot_re;
   logic signed [DATA_W-1:0]  rot_im;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv && !clear;
   assign accept    = in_valid && in_ready;
   assign out_valid = s2_valid;

   // Shifting within LOG2N bits is the mod-N reduction of the exponent
   always_comb begin
      e      = n_q << stride_q;
      q_raw  = e[LOG2N-1 -: 2];
      r      = e[LOG2N-3:0];
      r_i    = 32'(r);
      q_fold = quad_e'(q_raw);
      z_full = 0;
      if (r_i > N8) begin
         q_fold = quad_e'(q_raw + 2'd1);
         z_full = (N4 - r_i) * STEP;
      end else begin
         q_fold = quad_e'(q_raw);
         z_full = -(r_i * STEP);
      end
      z_next = z_full[ANGLE_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q      <= '0;
         stride_q <= '0;
      end else if (clear) begin
         n_q <= '0;
      end else if (accept) begin
         if (n_q == '0) stride_q <= cfg_stride_log2;
         n_q <= n_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_re    <= '0;
         s1_im    <= '0;
         s1_q     <= cordic_pkg::QUAD_0;
         s1_z     <= '0;
         s1_last  <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_re   <= in_real;
            s1_im   <= in_img;
            s1_q    <= q_fold;
            s1_z    <= z_next;
            s1_last <= &n_q;
         end
      end
   end

   cordic_quad_rot #(
      .W (DATA_W)
   ) u_quad_rot (
      .q      (s1_q),
      .re     (s1_re),
      .im     (s1_im),
      .rot_re (rot_re),
      .rot_im (rot_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_real <= '0;
         out_img  <= '0;
         out_z    <= '0;
         out_last <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_real <= rot_re;
            out_img  <= rot_im;
            out_z    <= s1_z;
            out_last <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_cordic_prerot_seq.sv
// Randomized bench for cordic_prerot_seq (N=64) against a twiddle-angle reference model.
module tb_cordic_prerot_seq;

   localparam int LOG2N = 6;
   localparam int N     = 1 << LOG2N;
   localparam int STEP  = 184320 / N;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               clear = 1'b0;
   logic [3:0]         cfg_stride_log2 = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_real = '0;
   logic signed [15:0] in_img = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_real;
   logic signed [15:0] out_img;
   logic signed [15:0] out_z;
   logic               out_last;

   cordic_prerot_seq #(
      .LOG2N   (LOG2N),
      .DATA_W  (16),
      .ANGLE_W (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear),
      .cfg_stride_log2 (cfg_stride_log2),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_real         (in_real),
      .in_img          (in_img),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_real        (out_real),
      .out_img         (out_img),
      .out_z           (out_z),
      .out_last        (out_last)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
      end
   endtask

   typedef struct {
      int n;
      int re;
      int im;
      int z;
      bit last;
   } exp_t;

   exp_t sb[$];

   function automatic int clamp16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic int ps(input int x);
      return (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
   endfunction

   // Twiddle W_N^e = exp(-j*2*pi*e/N); choose nearest quarter turn k (ties toward the lower
   // quadrant), rotate data by (-j)^k, leave the residual angle for the CORDIC.
   function automatic exp_t model(input int n, input int stride, input int re, input int im);
      exp_t m;
      int   e, k, a, b, t;
      e = (n * (1 << stride)) % N;
      k = (4 * e + N / 2 - 1) / N;
      m.z = -(e - k * (N / 4)) * STEP;
      a = re;
      b = im;
      for (int i = 0; i < (k % 4); i++) begin
         t = a;
         a = b;
         b = -t;
      end
      m.re = clamp16(a);
      m.im = clamp16(b);
`ifdef CORDIC_PRESCALE_EN
      m.re = ps(m.re);
      m.im = ps(m.im);
`endif
      m.n    = n;
      m.last = (n == N - 1);
      return m;
   endfunction

   int n_m = 0, stride_m = 0, phase = 0, cyc = 0;
   int first_acc = -1, first_out = -1;
   int force_low = 0;
   bit rnd_ready = 1'b0;
   bit saw_low = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic directed(input exp_t e);
      if (phase == 1) begin
         case (e.n)
            5:  check("n5_z", out_z, -14400);
            8:  check("n8_z", out_z, -23040);
            9:  check("n9_z", out_z, 20160);
            32: check("n32_z", out_z, 0);
            56: check("n56_z", out_z, -23040);
            63: check("n63_last", out_last, 1);
            default: ;
         endcase
`ifndef CORDIC_PRESCALE_EN
         case (e.n)
            5:  begin check("n5_re", out_real, 1000);  check("n5_im", out_img, 200);   end
            8:  begin check("n8_re", out_real, 1000);  check("n8_im", out_img, 200);   end
            9:  begin check("n9_re", out_real, 200);   check("n9_im", out_img, -1000); end
            32: begin check("n32_re", out_real, -1000); check("n32_im", out_img, -200); end
            56: begin check("n56_re", out_real, -200); check("n56_im", out_img, 1000); end
            default: ;
         endcase
`endif
      end
`ifndef CORDIC_PRESCALE_EN
      if (phase == 2) begin
         if (e.n == 32) begin check("sat32_re", out_real, 32767);  check("sat32_im", out_img, 0); end
         if (e.n == 16) begin check("sat16_re", out_real, -32768); check("sat16_im", out_img, 0); end
      end
`endif
      if (phase == 3 && e.n == 3) begin
         check("stride2_z", out_z, 11520);
`ifndef CORDIC_PRESCALE_EN
         check("stride2_re", out_real, 200);
         check("stride2_im", out_img, -1000);
`endif
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         check("in_ready", in_ready, (!clear && (sb.size() < 2 || out_ready)) ? 1 : 0);
         if (!in_ready && phase == 4) saw_low = 1'b1;
         if (out_valid) begin
            if (first_out < 0) first_out = cyc;
            if (sb.size() == 0) begin
               check("spurious_out", out_valid, 0);
            end else begin
               e = sb[0];
               check("out_real", out_real, e.re);
               check("out_img", out_img, e.im);
               check("out_z", out_z, e.z);
               check("out_last", out_last, e.last);
               if (out_ready) begin
                  void'(sb.pop_front());
                  directed(e);
               end
            end
         end
         if (in_valid && in_ready) begin
            if (n_m == 0) stride_m = int'(cfg_stride_log2);
            sb.push_back(model(n_m, stride_m, int'(in_real), int'(in_img)));
            n_m = (n_m + 1) % N;
            if (first_acc < 0) first_acc = cyc;
         end else if (clear) begin
            n_m = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (force_low > 0) begin
            out_ready = 1'b0;
            force_low--;
         end else if (rnd_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   task automatic send(input int re, input int im, input int cfg);
      bit done;
      done = 1'b0;
      in_valid        = 1'b1;
      in_real         = 16'(re);
      in_img          = 16'(im);
      cfg_stride_log2 = 4'(cfg);
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && sb.size() > 0; i++) idle(1);
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_real", out_real, 0);
      check("rst_out_img", out_img, 0);
      check("rst_out_z", out_z, 0);
      check("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      idle(1);

      phase = 1;
      for (int i = 0; i < N; i++) send(1000, 200, 0);
      drain();
      check("latency", first_out - first_acc, 2);

      phase = 2;
      for (int i = 0; i < N; i++) begin
         if (i == 32)      send(-32768, 0, 0);
         else if (i == 16) send(0, -32768, 0);
         else              send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 0);
      end
      drain();

      phase = 3;
      for (int i = 0; i < N; i++) send(1000, 200, (i == 0) ? 2 : 0);
      drain();

      phase = 4;
      rnd_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) begin
            if (f == 0 && i == 30) force_low = 5;
            send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
         end
      end
      rnd_ready = 1'b0;
      drain();
      check("stall_backpressure", saw_low, 1);

      phase = 5;
      for (int i = 0; i < 20; i++) send($urandom_range(0, 4000) - 2000, 300, 0);
      in_valid = 1'b1;
      clear    = 1'b1;
      @(negedge clk);
      check("clear_blocks", in_ready, 0);
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) send($urandom_range(0, 4000) - 2000, -700, 1);
      drain();

      phase = 6;
      for (int i = 0; i < 10; i++) send(1234, -321, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_z", out_z, 0);
      sb.delete();
      n_m      = 0;
      stride_m = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(1);
      for (int i = 0; i < N; i++) send($urandom_range(0, 65535) - 32768, 555, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
